// File: rtl/switch_input_capture.sv
// Conditions the board's slide switches and push-button, then captures the debounced switch word
// on each button press and offers it to the CPU over a valid/ready handshake.
module switch_input_capture #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned SAMPLES  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_in,
  output logic             data_valid,
  output logic [WIDTH-1:0] sw_db,
  output logic             btn_db,
  output logic             overrun
);

  localparam int unsigned N    = WIDTH + 1;
  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StHold, StWaitRel} state_e;

  // Bit WIDTH of every per-input vector carries the button; the lower bits are the switches.
  logic [N-1:0]              sync1_q, sync2_q;
  logic [CntW-1:0]           cnt_q;
  logic                      tick;
  logic [N-1:0][SAMPLES-1:0] hist_q;
  logic [N-1:0]              db_q;
  logic                      btn_db_q;
  logic                      btn_rise;
  state_e                    state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {btn, sw};
      sync2_q <= sync1_q;
    end
  end

  assign tick = (cnt_q == CntMax);

  always_ff @(posedge clk) begin
    if (rst)       cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + 1'b1;
  end

  // The level only moves once SAMPLES consecutive tick samples agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      db_q   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (tick) hist_q[i] <= (hist_q[i] << 1) | SAMPLES'(sync2_q[i]);
        if (&hist_q[i])       db_q[i] <= 1'b1;
        else if (~|hist_q[i]) db_q[i] <= 1'b0;
      end
    end
  end

  assign sw_db  = db_q[WIDTH-1:0];
  assign btn_db = db_q[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) btn_db_q <= 1'b0;
    else     btn_db_q <= btn_db;
  end

  assign btn_rise = btn_db & ~btn_db_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      data_in    <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (btn_rise) begin
            data_in    <= sw_db;
            data_valid <= 1'b1;
            state_q    <= StHold;
          end
        end
        StHold: begin
          // A press coinciding with the handshake is dropped and counts as no overrun.
          if (data_ready) begin
            data_valid <= 1'b0;
            state_q    <= btn_db ? StWaitRel : StIdle;
          end else if (btn_rise) begin
            overrun <= 1'b1;
          end
        end
        StWaitRel: begin
          if (!btn_db) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_input_capture.sv
// Directed bench for switch_input_capture: a per-cycle reference model plus hand-computed checks.
module tb_switch_input_capture;

  localparam int W  = 10;
  localparam int TD = 4;
  localparam int S  = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] sw = '0;
  logic         btn = 1'b0;
  logic         data_ready = 1'b0;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic [W-1:0] sw_db;
  logic         btn_db;
  logic         overrun;

  switch_input_capture #(
    .WIDTH    (W),
    .TICK_DIV (TD),
    .SAMPLES  (S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .btn        (btn),
    .data_ready (data_ready),
    .data_in    (data_in),
    .data_valid (data_valid),
    .sw_db      (sw_db),
    .btn_db     (btn_db),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: edges counted from reset; a tick every TD-th edge samples the input
  // applied two edges earlier; a level moves once the last S tick samples all agree.
  bit           mvalid = 1'b0;
  int unsigned  j;
  logic [W:0]   in_q[$];
  logic [W:0]   tq[$];
  logic [W:0]   m_db, m_db_prev, smp, all1, all0;
  bit           m_pend, m_wait, m_ovr, rise, bdb;
  logic [W-1:0] m_word;

  always @(posedge clk) begin
    if (rst) begin
      mvalid    = 1'b1;
      j         = 0;
      in_q      = {};
      in_q.push_back('0);
      tq        = {};
      for (int k = 0; k < S; k++) tq.push_back('0);
      m_db      = '0;
      m_db_prev = '0;
      m_pend    = 1'b0;
      m_wait    = 1'b0;
      m_ovr     = 1'b0;
      m_word    = '0;
    end else if (mvalid) begin
      j++;
      in_q.push_back({btn, sw});
      smp  = (j >= 2) ? in_q[j-2] : '0;
      bdb  = m_db[W];
      rise = bdb & ~m_db_prev[W];
      if (m_pend) begin
        if (data_ready) begin
          m_pend = 1'b0;
          m_wait = bdb;
        end else if (rise) begin
          m_ovr = 1'b1;
        end
      end else if (m_wait) begin
        if (!bdb) m_wait = 1'b0;
      end else if (rise) begin
        m_pend = 1'b1;
        m_word = m_db[W-1:0];
      end
      all1 = '1;
      all0 = '1;
      foreach (tq[k]) begin
        all1 &= tq[k];
        all0 &= ~tq[k];
      end
      m_db_prev = m_db;
      m_db      = (m_db & ~all0) | all1;
      if (j % TD == 0) begin
        tq.push_back(smp);
        void'(tq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("cmp sw_db", sw_db, m_db[W-1:0]);
      check("cmp btn_db", W'(btn_db), W'(m_db[W]));
      check("cmp data_valid", W'(data_valid), W'(m_pend));
      check("cmp data_in", data_in, m_word);
      check("cmp overrun", W'(overrun), W'(m_ovr));
    end
  end

  initial begin
    // 1: reset with arbitrary inputs applied
    sw  = 10'h1C3;
    btn = 1'b1;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sw  = '0;
    btn = 1'b0;
    check("t1 data_in", data_in, 10'h000);
    check("t1 data_valid", W'(data_valid), 10'h0);
    check("t1 sw_db", sw_db, 10'h000);
    check("t1 btn_db", W'(btn_db), 10'h0);
    check("t1 overrun", W'(overrun), 10'h0);

    // 2: debounce and glitch rejection
    sw = 10'h2A5;
    repeat (15) cyc();
    check("t2 sw_db settled", sw_db, 10'h2A5);
    sw = 10'h2A4;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t2 glitch hold", sw_db, 10'h2A5);
    end
    sw = 10'h2A5;
    for (int i = 0; i < 16; i++) begin
      cyc();
      check("t2 glitch after", sw_db, 10'h2A5);
    end

    // 3: capture, then switch changes are ignored
    sw = 10'h3FF;
    repeat (16) cyc();
    btn = 1'b1;
    repeat (20) cyc();
    check("t3 data_valid", W'(data_valid), 10'h1);
    check("t3 data_in", data_in, 10'h3FF);
    sw = 10'h001;
    repeat (20) cyc();
    check("t3 data_in frozen", data_in, 10'h3FF);
    check("t3 sw_db live", sw_db, 10'h001);

    // 4: handshake while held, no retrigger, then a fresh press
    data_ready = 1'b1;
    cyc();
    data_ready = 1'b0;
    check("t4 valid cleared", W'(data_valid), 10'h0);
    for (int i = 0; i < 40; i++) begin
      cyc();
      check("t4 no retrigger", W'(data_valid), 10'h0);
    end
    btn = 1'b0;
    repeat (20) cyc();
    sw = 10'h155;
    repeat (16) cyc();
    btn = 1'b1;
    repeat (20) cyc();
    check("t4 data_in", data_in, 10'h155);
    check("t4 data_valid", W'(data_valid), 10'h1);

    // 5: overrun from a second press while pending
    btn = 1'b0;
    repeat (20) cyc();
    sw = 10'h0F0;
    repeat (16) cyc();
    btn = 1'b1;
    repeat (20) cyc();
    check("t5 overrun", W'(overrun), 10'h1);
    check("t5 data_in kept", data_in, 10'h155);
    check("t5 still valid", W'(data_valid), 10'h1);
    data_ready = 1'b1;
    cyc();
    data_ready = 1'b0;
    check("t5 valid cleared", W'(data_valid), 10'h0);
    check("t5 overrun sticky", W'(overrun), 10'h1);
    btn = 1'b0;
    repeat (20) cyc();

    // 6: reset in HOLD together with data_ready
    btn = 1'b1;
    repeat (20) cyc();
    check("t6 pre data_in", data_in, 10'h0F0);
    check("t6 pre valid", W'(data_valid), 10'h1);
    rst        = 1'b1;
    data_ready = 1'b1;
    cyc();
    rst        = 1'b0;
    data_ready = 1'b0;
    check("t6 valid", W'(data_valid), 10'h0);
    check("t6 overrun", W'(overrun), 10'h0);
    check("t6 data_in", data_in, 10'h000);
    check("t6 sw_db", sw_db, 10'h000);
    repeat (20) cyc();
    check("t6 recapture valid", W'(data_valid), 10'h1);
    check("t6 recapture data", data_in, 10'h0F0);
    check("t6 recapture ovr", W'(overrun), 10'h0);
    data_ready = 1'b1;
    cyc();
    data_ready = 1'b0;
    check("t6 final valid", W'(data_valid), 10'h0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_input_capture.md
Name: switch_input_capture

Overview:
Input-side companion to the four-digit hex display driver: conditions the board's 10 slide switches and one push-button, and delivers a debounced 10-bit operand word to the CPU. Each button press captures the debounced switches into a holding register. The word is offered to the CPU with a valid/ready handshake. Debounced switch levels are also exported live for LED mirroring.

Parameters:
WIDTH, 10, width of switch bus and captured word
TICK_DIV, 100000, clk cycles per debounce sample tick (1 ms at 100 MHz)
SAMPLES, 3, consecutive agreeing samples required to change a debounced level

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sw  input  WIDTH  raw slide switches, asynchronous
btn  input  1  raw push-button (1 = pressed), asynchronous
data_ready  input  1  CPU accepts data_in this cycle
data_in  output  WIDTH  captured switch word to CPU
data_valid  output  1  data_in holds an unconsumed word
sw_db  output  WIDTH  debounced switch levels
btn_db  output  1  debounced button level
overrun  output  1  sticky: press occurred while a word was pending

Behaviour:
- Reset: one clock with rst=1 clears every register:
  - sync flops, sample histories and tick counter = 0
  - sw_db = 0, btn_db = 0, data_in = 0, data_valid = 0, overrun = 0
  - FSM = IDLE
  - rst dominates every other event in the same cycle, including mid-handshake.
- Synchronisers: each of the WIDTH+1 raw inputs passes through a 2-flop synchroniser before any use.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 for exactly one cycle when count == TICK_DIV-1.
- Debounce, per input:
  - On tick, shift the synchronised value into a SAMPLES-bit history.
  - If all SAMPLES history bits equal v, the debounced output becomes v on the following edge; otherwise it holds.
  - Any pulse shorter than (SAMPLES-1)*TICK_DIV cycles is never propagated.
  - Worst-case latency from a raw change to debounced output: 2 + SAMPLES*TICK_DIV + 1 cycles.
- Press detection: btn_rise = btn_db & ~btn_db_q, where btn_db_q is btn_db delayed one cycle. Exactly one pulse per debounced press.
- FSM:
  - IDLE:
    - data_valid = 0.
    - On btn_rise: data_in <= sw_db, data_valid <= 1, go to HOLD. Outputs are visible the cycle after btn_rise.
  - HOLD:
    - data_valid = 1; data_in is frozen (switch changes are ignored).
    - data_ready = 1 (sampled at the edge): data_valid <= 0. Go to WAIT_REL if btn_db = 1, else IDLE.
    - btn_rise with data_ready = 0: overrun <= 1; data_in unchanged; stay in HOLD.
    - btn_rise and data_ready in the same cycle: the handshake completes and the new press is not captured. No overrun, go to WAIT_REL.
  - WAIT_REL:
    - data_valid = 0.
    - When btn_db = 0, go to IDLE. Holding the button never retriggers a capture.
- data_ready while data_valid = 0 is ignored.
- overrun is cleared only by rst.
- Arithmetic: all counters are unsigned. Tick counter width is clog2(TICK_DIV). No other arithmetic.

Test Plan:
(All tests use TICK_DIV=4, SAMPLES=3.)
1. Reset: drive arbitrary sw/btn, pulse rst one cycle -> next cycle data_in=0x000, data_valid=0, sw_db=0x000, btn_db=0, overrun=0.
2. Debounce: sw=0x2A5 held stable -> sw_db=0x2A5 within 15 cycles. Then a 3-cycle glitch of sw[0] to 0 -> sw_db stays 0x2A5 throughout.
3. Capture: sw=0x3FF settled, btn held 20 cycles -> data_valid=1, data_in=0x3FF. Change sw to 0x001 while data_ready=0 -> data_in stays 0x3FF.
4. Handshake/no retrigger: in HOLD with btn still pressed, assert data_ready one cycle -> data_valid=0 next cycle, FSM=WAIT_REL. Keep btn held 40 cycles -> no new data_valid. Release, then press with sw=0x155 -> data_in=0x155, data_valid=1.
5. Overrun: in HOLD with data_ready=0, release btn and re-press with sw=0x0F0 -> overrun=1, data_in unchanged. Then data_ready -> data_valid=0, overrun remains 1.
6. Reset mid-operation: assert rst in HOLD together with data_ready=1 -> data_valid=0, overrun=0, FSM=IDLE. The next press captures normally.
